// File: rtl/param_voting_machine.sv
// Parametrised ballot controller: password-gated polls with brute-force lockout,
// per-voter single ballot, saturating tallies and a sequential winner scan.
module param_voting_machine #(
  parameter int unsigned            NUM_CAND      = 4,
  parameter int unsigned            VOTER_ID_W    = 6,
  parameter int unsigned            COUNT_W       = 10,
  parameter int unsigned            PASSWORD_W    = 8,
  parameter logic [PASSWORD_W-1:0]  PASSWORD      = 8'hA5,
  parameter int unsigned            MAX_AUTH_FAIL = 3,
  localparam int unsigned           SEL_W         = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [PASSWORD_W-1:0]        admin_password,
  input  logic                         enable_admin,
  input  logic                         result_mode,
  input  logic [VOTER_ID_W-1:0]        voter_id,
  input  logic                         vote_valid,
  input  logic [SEL_W-1:0]             vote_sel,
  output logic [NUM_CAND*COUNT_W-1:0]  count_flat,
  output logic [VOTER_ID_W:0]          total_votes,
  output logic [SEL_W-1:0]             winner,
  output logic                         tie_flag,
  output logic                         result_valid,
  output logic                         voting_enabled,
  output logic                         busy,
  output logic                         lockout,
  output logic                         vote_reject,
  output logic [1:0]                   reject_code
);

  localparam int unsigned NUM_VOTERS = 2 ** VOTER_ID_W;
  localparam int unsigned FAIL_W     = 4;

  typedef enum logic [2:0] {
    S_AUTH, S_IDLE, S_VOTE, S_LOCK, S_SCAN, S_RESULT, S_LOCKOUT
  } state_t;

  state_t                  r_state;
  logic [COUNT_W-1:0]      r_count [NUM_CAND];
  logic [NUM_VOTERS-1:0]   r_voted;
  logic [VOTER_ID_W:0]     r_total;
  logic [FAIL_W-1:0]       r_fail;
  logic [SEL_W-1:0]        r_sel;
  logic [VOTER_ID_W-1:0]   r_id;
  logic [SEL_W-1:0]        r_scan_idx;
  logic [COUNT_W-1:0]      r_max;
  logic [SEL_W-1:0]        r_winner;
  logic                    r_tie;
  logic                    r_result_valid;
  logic                    r_voting_enabled;
  logic                    r_busy;
  logic                    r_lockout;
  logic                    r_vote_reject;
  logic [1:0]              r_reject_code;

  logic                    w_sel_bad;
  logic [COUNT_W-1:0]      w_scan_cnt;

  assign w_sel_bad  = {1'b0, vote_sel} >= (SEL_W+1)'(NUM_CAND);
  assign w_scan_cnt = r_count[r_scan_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= S_AUTH;
      for (int i = 0; i < NUM_CAND; i++) r_count[i] <= '0;
      r_voted          <= '0;
      r_total          <= '0;
      r_fail           <= '0;
      r_sel            <= '0;
      r_id             <= '0;
      r_scan_idx       <= '0;
      r_max            <= '0;
      r_winner         <= '0;
      r_tie            <= 1'b0;
      r_result_valid   <= 1'b0;
      r_voting_enabled <= 1'b0;
      r_busy           <= 1'b0;
      r_lockout        <= 1'b0;
      r_vote_reject    <= 1'b0;
      r_reject_code    <= 2'b00;
    end else begin
      r_vote_reject <= 1'b0;
      case (r_state)
        S_AUTH: begin
          if (enable_admin) begin
            if (admin_password == PASSWORD) begin
              r_state          <= S_IDLE;
              r_voting_enabled <= 1'b1;
              r_fail           <= '0;
            end else begin
              r_fail <= r_fail + FAIL_W'(1);
              if (r_fail + FAIL_W'(1) == FAIL_W'(MAX_AUTH_FAIL)) begin
                r_state   <= S_LOCKOUT;
                r_lockout <= 1'b1;
              end
            end
          end
        end
        S_IDLE: begin
          if (result_mode) begin
            r_state          <= S_SCAN;
            r_voting_enabled <= 1'b0;
            r_busy           <= 1'b1;
            r_scan_idx       <= '0;
          end else if (vote_valid) begin
            r_busy <= 1'b1;
            // Rejection precedence: duplicate voter, bad index, saturated tally.
            if (r_voted[voter_id]) begin
              r_state       <= S_LOCK;
              r_vote_reject <= 1'b1;
              r_reject_code <= 2'b01;
            end else if (w_sel_bad) begin
              r_state       <= S_LOCK;
              r_vote_reject <= 1'b1;
              r_reject_code <= 2'b10;
            end else if (r_count[vote_sel] == '1) begin
              r_state       <= S_LOCK;
              r_vote_reject <= 1'b1;
              r_reject_code <= 2'b11;
            end else begin
              r_state <= S_VOTE;
              r_sel   <= vote_sel;
              r_id    <= voter_id;
            end
          end
        end
        S_VOTE: begin
          r_count[r_sel] <= r_count[r_sel] + COUNT_W'(1);
          r_total        <= r_total + (VOTER_ID_W+1)'(1);
          r_voted[r_id]  <= 1'b1;
          r_state        <= S_LOCK;
        end
        S_LOCK: begin
          if (!vote_valid) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_SCAN: begin
          // Running max; ties keep the lower index.
          if (r_scan_idx == '0) begin
            r_max    <= w_scan_cnt;
            r_winner <= '0;
            r_tie    <= 1'b0;
          end else if (w_scan_cnt > r_max) begin
            r_max    <= w_scan_cnt;
            r_winner <= r_scan_idx;
            r_tie    <= 1'b0;
          end else if (w_scan_cnt == r_max) begin
            r_tie <= 1'b1;
          end
          if (r_scan_idx == SEL_W'(NUM_CAND - 1)) begin
            r_state        <= S_RESULT;
            r_result_valid <= 1'b1;
            r_busy         <= 1'b0;
          end else begin
            r_scan_idx <= r_scan_idx + SEL_W'(1);
          end
        end
        S_RESULT:  r_state <= S_RESULT;
        S_LOCKOUT: r_state <= S_LOCKOUT;
        default:   r_state <= S_AUTH;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CAND; g++) begin : g_flat
    assign count_flat[g*COUNT_W +: COUNT_W] = r_count[g];
  end

  assign total_votes    = r_total;
  assign winner         = r_winner;
  assign tie_flag       = r_tie;
  assign result_valid   = r_result_valid;
  assign voting_enabled = r_voting_enabled;
  assign busy           = r_busy;
  assign lockout        = r_lockout;
  assign vote_reject    = r_vote_reject;
  assign reject_code    = r_reject_code;

endmodule
